// File: rtl/prog_mem_ctrl_if.sv
// ---------------------------------------------------------------------------
// prog_mem_ctrl_if
// Request/response bus between a requester and the program memory controller.
//   RD, WR          : read / program-load request, held until Ready
//   BusDirecciones  : byte address of the access
//   BusDatosIn      : write data
//   BusDatos        : registered read data from the controller
//   Ready           : one-cycle completion pulse
//   Fault           : one-cycle error pulse, coincident with Ready
// Modports: master = requester side, slave = controller side.
// ---------------------------------------------------------------------------
interface prog_mem_ctrl_if #(
    parameter int DATAWIDTH_BUS = 32
);
    logic                     RD;
    logic                     WR;
    logic [DATAWIDTH_BUS-1:0] BusDirecciones;
    logic [DATAWIDTH_BUS-1:0] BusDatosIn;
    logic [DATAWIDTH_BUS-1:0] BusDatos;
    logic                     Ready;
    logic                     Fault;

    modport master (
        output RD, WR, BusDirecciones, BusDatosIn,
        input  BusDatos, Ready, Fault
    );

    modport slave (
        input  RD, WR, BusDirecciones, BusDatosIn,
        output BusDatos, Ready, Fault
    );
endinterface

// File: rtl/prog_mem_ctrl.sv
// ---------------------------------------------------------------------------
// prog_mem_ctrl
// Word-addressed program memory behind a simple request bus. Each access is
// captured in IDLE, waits WAIT_STATES cycles, then completes in DONE with a
// one-cycle Ready pulse (plus Fault for misaligned, out-of-range or
// conflicting requests). Reads update the registered BusDatos; writes load a
// program word. Reset clears the whole memory to zero (the "fin" encoding).
// Ports:
//   CLOCK_50     : clock, all state changes on the rising edge
//   RESET_InLow  : asynchronous active-low reset
//   bus          : prog_mem_ctrl_if slave modport (RD, WR, BusDirecciones,
//                  BusDatosIn, BusDatos, Ready, Fault)
// ---------------------------------------------------------------------------
module prog_mem_ctrl #(
    parameter int                       DATAWIDTH_BUS = 32,
    parameter int                       MEM_DEPTH     = 64,
    parameter logic [DATAWIDTH_BUS-1:0] BASE_ADDR     = 32'h0000_0800,
    parameter int                       WAIT_STATES   = 1
) (
    input  logic           CLOCK_50,
    input  logic           RESET_InLow,
    prog_mem_ctrl_if.slave bus
);
    localparam int IDXW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, DONE} stateT;

    stateT                    state;
    stateT                    nextState;
    logic [3:0]               waitCnt;
    logic                     startReq;
    logic                     enterDone;

    logic [DATAWIDTH_BUS-1:0] capAddr;
    logic [DATAWIDTH_BUS-1:0] capData;
    logic                     capRd;
    logic                     capWr;

    logic [DATAWIDTH_BUS-1:0] evalAddr;
    logic [DATAWIDTH_BUS-1:0] evalData;
    logic                     evalRd;
    logic                     evalWr;
    logic [DATAWIDTH_BUS-1:0] offset;
    logic [DATAWIDTH_BUS-1:0] wordIndex;
    logic [IDXW-1:0]          memIdx;
    logic                     accessFault;

    logic [DATAWIDTH_BUS-1:0] readData;
    logic [DATAWIDTH_BUS-1:0] mem [MEM_DEPTH];

    // With WAIT_STATES=0 the capture edge is also the edge entering DONE, so
    // the captured registers are not yet loaded; evaluate the live bus then.
    always_comb begin
        evalAddr = capAddr;
        evalData = capData;
        evalRd   = capRd;
        evalWr   = capWr;
        if (state == IDLE) begin
            evalAddr = bus.BusDirecciones;
            evalData = bus.BusDatosIn;
            evalRd   = bus.RD;
            evalWr   = bus.WR;
        end
    end

    // Below-base is checked separately so the subtraction cannot wrap into
    // a valid-looking index.
    always_comb begin
        offset      = evalAddr - BASE_ADDR;
        wordIndex   = offset >> 2;
        memIdx      = IDXW'(wordIndex);
        accessFault = (evalAddr[1:0] != 2'b00)
                    | (evalAddr < BASE_ADDR)
                    | (wordIndex >= DATAWIDTH_BUS'(MEM_DEPTH))
                    | (evalRd & evalWr);
    end

    always_comb begin
        nextState = state;
        startReq  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.RD || bus.WR) begin
                    startReq  = 1'b1;
                    nextState = (WAIT_STATES == 0) ? DONE : WAIT;
                end
            end
            WAIT: begin
                if (waitCnt <= 4'd1) begin
                    nextState = DONE;
                end
            end
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    assign enterDone    = (nextState == DONE) && (state != DONE);
    assign bus.Ready    = (state == DONE);
    assign bus.Fault    = (state == DONE) && accessFault;
    assign bus.BusDatos = readData;

    always_ff @(posedge CLOCK_50 or negedge RESET_InLow) begin
        if (!RESET_InLow) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_InLow) begin
        if (!RESET_InLow) begin
            waitCnt <= 4'd0;
            capAddr <= '0;
            capData <= '0;
            capRd   <= 1'b0;
            capWr   <= 1'b0;
        end else if (startReq) begin
            waitCnt <= 4'(WAIT_STATES);
            capAddr <= bus.BusDirecciones;
            capData <= bus.BusDatosIn;
            capRd   <= bus.RD;
            capWr   <= bus.WR;
        end else if (state == WAIT && waitCnt != 4'd0) begin
            waitCnt <= waitCnt - 4'd1;
        end
    end

    // Memory and read data only change on the edge entering DONE, and never
    // for a faulting access.
    always_ff @(posedge CLOCK_50 or negedge RESET_InLow) begin
        if (!RESET_InLow) begin
            readData <= '0;
            for (int i = 0; i < MEM_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (enterDone && !accessFault) begin
            if (evalWr) begin
                mem[memIdx] <= evalData;
            end else if (evalRd) begin
                readData <= mem[memIdx];
            end
        end
    end
endmodule

// File: doc/prog_mem_ctrl.md
PROG_MEM_CTRL -- requirements
Module: prog_mem_ctrl

Interface
REQ-001 Parameter DATAWIDTH_BUS, default 32: width of data bus, address bus and memory word, in bits.
REQ-002 Parameter MEM_DEPTH, default 64: number of words held.
REQ-003 Parameter BASE_ADDR, default 32'h0000_0800: byte address of word 0.
REQ-004 Parameter WAIT_STATES, default 1, range 0..15: extra cycles inserted before completion.
REQ-005 CLOCK_50  input  1: the single clock; all state changes on its rising edge.
REQ-006 RESET_InLow  input  1: reset; asynchronous, active-low.
REQ-007 RD  input  1: read request.
REQ-008 WR  input  1: write (program-load) request.
REQ-009 BusDirecciones  input  DATAWIDTH_BUS: byte address of the access.
REQ-010 BusDatosIn  input  DATAWIDTH_BUS: write data.
REQ-011 BusDatos  output  DATAWIDTH_BUS: registered read data.
REQ-012 Ready  output  1: one-cycle completion pulse.
REQ-013 Fault  output  1: one-cycle error pulse, coincident with Ready.

Function
REQ-014 The block SHALL implement FSM states IDLE, WAIT and DONE.
REQ-015 In IDLE, at edge t with RD or WR high, the block SHALL capture address, data and request type, then go to WAIT, or to DONE if WAIT_STATES=0.
REQ-016 The block SHALL ignore RD, WR, BusDirecciones and BusDatosIn outside IDLE; the requester holds the request until Ready.
REQ-017 WAIT SHALL last exactly WAIT_STATES cycles, counted by a down-counter loaded at edge t; DONE is entered at edge t+WAIT_STATES.
REQ-018 DONE SHALL last exactly one cycle and return to IDLE; Ready=1 only in DONE.
REQ-019 Throughput SHALL be one access per WAIT_STATES+2 cycles; a request still high in IDLE after DONE starts a new access.
REQ-020 Word index SHALL be (addr - BASE_ADDR) >> 2, computed from the captured address.
REQ-021 An access SHALL fault when addr[1:0] != 0, addr < BASE_ADDR, index >= MEM_DEPTH, or RD and WR are both high at capture.
REQ-022 A faulting access SHALL still traverse WAIT and DONE with full latency, assert Fault with Ready, leave memory unmodified and leave BusDatos unchanged.
REQ-023 A valid read SHALL load mem[index] into BusDatos on the edge entering DONE; BusDatos SHALL hold that value until the next valid read.
REQ-024 A valid write SHALL update mem[index] with the captured data on the edge entering DONE; BusDatos SHALL be unchanged.
REQ-025 Address arithmetic SHALL be unsigned DATAWIDTH_BUS bits with no wrap: below-base addresses fault and do not alias high words.

Reset
REQ-026 While RESET_InLow=0: state=IDLE, wait counter=0, Ready=0, Fault=0, BusDatos=0, all MEM_DEPTH words=0 (the zero word is the "fin" encoding).
REQ-027 Reset asserted mid-access SHALL abort it: a pending write is discarded and no Ready or Fault pulse is emitted.
REQ-028 After RESET_InLow rises, the first request SHALL be sampled no earlier than the first rising edge with reset high.

Verification (WAIT_STATES=1, BASE_ADDR=0x800, MEM_DEPTH=64 unless stated)
REQ-029 Reset, then RD=1 with addr 0x800 at edge t -> Ready=1, Fault=0 and BusDatos=0 during the cycle after edge t+1.
REQ-030 WR with addr 0x804 and data 0x82802001, then RD with addr 0x804 -> BusDatos=0x82802001, Fault=0; a read of 0x808 still returns 0.
REQ-031 RD with addr 0x802; RD with addr 0x900; WR with addr 0x7FC -> each gives Ready=1 and Fault=1 at normal latency; BusDatos and memory are unchanged.
REQ-032 RD=WR=1 with addr 0x804 and data 0xFFFFFFFF -> Fault=1; a later read of 0x804 returns its previous value.
REQ-033 WR with addr 0x810 and data 0x12345678, RESET_InLow pulsed low during WAIT -> no Ready pulse; a read of 0x810 after reset returns 0.
REQ-034 Rebuild with WAIT_STATES=0 and MEM_DEPTH=16: RD held high with addr 0x83C -> Ready every second cycle, Fault=0; addr 0x840 -> Fault=1.
